// File: rtl/bitty_core_p_if.sv
// bitty_core_p_if: instruction handshake, register readback and status bundle for bitty_core_p.
interface bitty_core_p_if #(parameter int DATA_W = 16);
    logic instr_valid, instr_ready, done, err, flag_z, flag_c;
    logic [15:0] instruction;
    logic [2:0] rd_addr;
    logic [DATA_W-1:0] rd_data, last_alu_result;
    modport master(
        output instr_valid, instruction, rd_addr,
        input instr_ready, done, err, rd_data, last_alu_result, flag_z, flag_c
    );
    modport slave(
        input instr_valid, instruction, rd_addr,
        output instr_ready, done, err, rd_data, last_alu_result, flag_z, flag_c
    );
endinterface

// File: rtl/bitty_core_p.sv
// bitty_core_p: four-cycle IDLE/FETCH/EXEC/WB bitty core over a parametrised register file.
// Define BITTY_CORE_FLAGS_EN to build the zero/carry flag registers; otherwise the flags are tied low.
module bitty_core_p #(
    parameter int DATA_W = 16,
    parameter int NUM_REGS = 8
) (
    input logic clk,
    input logic reset,
    bitty_core_p_if.slave bus
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int SW = $clog2(DATA_W);
    localparam logic [3:0] NR = 4'(NUM_REGS);
`ifdef BITTY_CORE_FLAGS_EN
    localparam int XW = DATA_W + 1;
`else
    localparam int XW = DATA_W;
`endif
    localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, EXEC = 2'd2, WB = 2'd3;

    logic [1:0] state_q, state_d;
    logic [15:0] inst_q;
    logic [DATA_W-1:0] s_q, c_q, b, regs_q [NUM_REGS];
    logic [XW-1:0] alu_x;
    logic err_q, legal, accept;
    logic [RW-1:0] rx, ry;

    assign legal = !bus.instruction[1] && {1'b0, bus.instruction[15:13]} < NR &&
                   (bus.instruction[0] || {1'b0, bus.instruction[12:10]} < NR);
    assign accept = state_q == IDLE && bus.instr_valid && legal;
    assign rx = inst_q[13 +: RW];
    assign ry = inst_q[10 +: RW];
    assign b = inst_q[1:0] == 2'b01 ? DATA_W'(inst_q[12:5]) : regs_q[ry];

    assign state_d = state_q == IDLE  ? (accept ? FETCH : IDLE) :
                     state_q == FETCH ? EXEC :
                     state_q == EXEC  ? WB : IDLE;

    // The extra top bit (when flags are built) carries add carry-out / sub borrow; other ops leave it 0.
    always_comb begin
        alu_x = '0;
        case (inst_q[4:2])
            3'd0: alu_x = XW'(s_q) + XW'(b);
            3'd1: alu_x = XW'(s_q) - XW'(b);
            3'd2: alu_x = XW'(s_q & b);
            3'd3: alu_x = XW'(s_q | b);
            3'd4: alu_x = XW'(s_q ^ b);
            3'd5: alu_x = XW'(s_q << b[SW-1:0]);
            3'd6: alu_x = XW'(s_q >> b[SW-1:0]);
            default: alu_x = s_q == b ? '0 : s_q > b ? XW'(1) : XW'(2);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            inst_q <= '0;
            s_q <= '0;
            c_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            err_q <= state_q == IDLE && bus.instr_valid && !legal;
            if (accept) inst_q <= bus.instruction;
            if (state_q == FETCH) s_q <= regs_q[rx];
            if (state_q == EXEC) c_q <= alu_x[DATA_W-1:0];
            if (state_q == WB) regs_q[rx] <= c_q;
        end
    end

`ifdef BITTY_CORE_FLAGS_EN
    logic fz_q, fc_q;
    always_ff @(posedge clk) begin
        if (reset) {fz_q, fc_q} <= 2'b00;
        else if (state_q == EXEC) {fz_q, fc_q} <= {alu_x[DATA_W-1:0] == '0, alu_x[DATA_W]};
    end
    assign bus.flag_z = fz_q;
    assign bus.flag_c = fc_q;
`else
    assign bus.flag_z = 1'b0;
    assign bus.flag_c = 1'b0;
`endif

    assign bus.instr_ready = state_q == IDLE;
    assign bus.done = state_q == WB;
    assign bus.err = err_q;
    assign bus.last_alu_result = c_q;
    assign bus.rd_data = {1'b0, bus.rd_addr} < NR ? regs_q[bus.rd_addr[RW-1:0]] : '0;
endmodule

// File: tb/tb_bitty_core_p.sv
// tb_bitty_core_p: directed and random instruction checks of bitty_core_p against an integer reference model.
module tb_bitty_core_p;
    logic clk = 1'b0, reset = 1'b1;
    int cmps = 0, fails = 0;
    int unsigned mr [8];
    int unsigned mc;
    bit mz, mcf;
    logic [15:0] ri;

    always #5 clk = ~clk;

    bitty_core_p_if #(.DATA_W(16)) bus();
    bitty_core_p_if #(.DATA_W(16)) bus4();
    bitty_core_p #(.DATA_W(16), .NUM_REGS(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    bitty_core_p #(.DATA_W(16), .NUM_REGS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        foreach (mr[i]) mr[i] = 0;
        mc = 0;
        mz = 0;
        mcf = 0;
    endfunction

    function automatic bit legal(input logic [15:0] in, input int nr);
        return in[1] == 1'b0 && int'(in[15:13]) < nr && (in[1:0] == 2'b01 || int'(in[12:10]) < nr);
    endfunction

    // Plain 16-bit integer semantics of one instruction.
    function automatic void model(input logic [15:0] in);
        int unsigned a, b, r, sh;
        a = mr[in[15:13]];
        b = in[1:0] == 2'b00 ? mr[in[12:10]] : int'(in[12:5]);
        sh = b % 16;
        mcf = 0;
        case (in[4:2])
            3'd0: begin r = a + b; mcf = r > 65535; end
            3'd1: begin mcf = a < b; r = a + 65536 - b; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << sh;
            3'd6: r = a >> sh;
            default: r = a == b ? 0 : a > b ? 1 : 2;
        endcase
        mc = r % 65536;
        mz = mc == 0;
        mr[in[15:13]] = mc;
    endfunction

    task automatic chk_flags();
`ifdef BITTY_CORE_FLAGS_EN
        chk("flag_z", bus.flag_z, mz);
        chk("flag_c", bus.flag_c, mcf);
`else
        chk("flag_z", bus.flag_z, 0);
        chk("flag_c", bus.flag_c, 0);
`endif
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            bus.rd_addr = 3'(i);
            #1;
            chk(tag, bus.rd_data, mr[i]);
        end
    endtask

    task automatic run(input logic [15:0] in, input bit hold);
        int unsigned old = mr[in[15:13]];
        bus.rd_addr = in[15:13];
        chk("ready_idle", bus.instr_ready, 1);
        bus.instr_valid = 1'b1;
        bus.instruction = in;
        tick;
        model(in);
        for (int k = 1; k <= 3; k++) begin
            bus.instr_valid = hold;
            bus.instruction = 16'($urandom);
            chk("ready_busy", bus.instr_ready, 0);
            chk("done_timing", bus.done, k == 3);
            chk("err_busy", bus.err, 0);
            if (k == 3) chk("rd_old_in_wb", bus.rd_data, old);
            tick;
        end
        bus.instr_valid = 1'b0;
        chk("done_after", bus.done, 0);
        chk("ready_after", bus.instr_ready, 1);
        chk("err_after", bus.err, 0);
        chk("rd_new", bus.rd_data, mr[in[15:13]]);
        chk("last_alu", bus.last_alu_result, mc);
        chk_flags();
    endtask

    task automatic illegal(input logic [15:0] in);
        bus.instr_valid = 1'b1;
        bus.instruction = in;
        tick;
        bus.instr_valid = 1'b0;
        chk("err_pulse", bus.err, 1);
        chk("ready_ill", bus.instr_ready, 1);
        chk("done_ill", bus.done, 0);
        tick;
        chk("err_clear", bus.err, 0);
        chk("done_ill2", bus.done, 0);
        chk("last_alu_ill", bus.last_alu_result, mc);
        chk_flags();
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instruction = '0;
        bus.rd_addr = '0;
        bus4.instr_valid = 1'b0;
        bus4.instruction = '0;
        bus4.rd_addr = '0;
        model_reset();
        tick;
        tick;
        reset = 1'b0;
        tick;
        chk("rst_ready", bus.instr_ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_alu", bus.last_alu_result, 0);
        chk_flags();
        chk_regs("rst_reg");

        run(16'h20A1, 1'b0);
        chk("imm_add_r1", bus.rd_data, 16'h0005);
        run(16'h4025, 1'b0);
        chk("sub_wrap_r2", bus.rd_data, 16'hFFFF);
        run(16'h4021, 1'b0);
        chk("add_wrap_r2", bus.rd_data, 16'h0000);
        run(16'h6061, 1'b0);
        run(16'h2C10, 1'b1);
        chk("xor_r1", bus.rd_data, 16'h0006);

        illegal(16'h0003);
        chk_regs("ill_regs");

        repeat (60) begin
            ri = 16'($urandom);
            if (legal(ri, 8)) run(ri, 1'($urandom));
            else illegal(ri);
        end
        chk_regs("rand_regs");

        bus4.rd_addr = 3'd5;
        bus4.instr_valid = 1'b1;
        bus4.instruction = 16'h8001;
        #1;
        chk("nr4_rd_oob", bus4.rd_data, 0);
        tick;
        bus4.instr_valid = 1'b0;
        chk("nr4_err", bus4.err, 1);
        chk("nr4_ready", bus4.instr_ready, 1);
        chk("nr4_done", bus4.done, 0);

        bus.rd_addr = 3'd1;
        bus.instr_valid = 1'b1;
        bus.instruction = 16'h20A1;
        tick;
        bus.instr_valid = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        model_reset();
        chk("abort_done", bus.done, 0);
        tick;
        chk("abort_done2", bus.done, 0);
        chk("abort_ready", bus.instr_ready, 1);
        chk("abort_alu", bus.last_alu_result, 0);
        chk("abort_r1", bus.rd_data, 0);
        chk_flags();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
        $finish;
    end
endmodule
